// File: rtl/arm_control_sequencer.sv
// Microsequencer for the ARM control unit: fetch/decode/execute stepping,
// datapath load strobes and the MFA/MOC memory handshake with a timeout watchdog.
//
// state | meaning
// ------+------------------------------------------------------------
//   0   | RESET       idle cycle after reset or bus error
//   1   | FETCH_ADDR  MAR <- PC
//   2   | FETCH_INC   PC <- PC+4, start instruction read
//   3   | FETCH_WAIT  wait for MOC, IR loads on MOC
//   4   | DECODE      jump to encoder state or retire
//  10   | DP_EXEC     register file and flags write
//  16   | LD_IMM      effective address to MAR
//  19   | LD_REG      effective address to MAR
//  20   | LD_WAIT     wait for MOC, MDR loads on MOC
//  21   | LD_WB       register file write-back
//  17   | ST_ADDR     address to MAR
//  22   | ST_DATA     store data to MDR
//  23   | ST_WAIT     write cycle, wait for MOC
module arm_control_sequencer #(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] enc_state_i,
  input  logic       cond_true_i,
  input  logic       moc_i,
  output logic [7:0] state_o,
  output logic       mar_ld_o,
  output logic       pc_ld_o,
  output logic       ir_ld_o,
  output logic       mdr_ld_o,
  output logic       rf_ld_o,
  output logic       flags_ld_o,
  output logic       mfa_o,
  output logic       rw_o,
  output logic       illegal_o,
  output logic       instr_done_o,
  output logic       bus_err_o
);

  localparam logic [7:0] S_RESET      = 8'd0;
  localparam logic [7:0] S_FETCH_ADDR = 8'd1;
  localparam logic [7:0] S_FETCH_INC  = 8'd2;
  localparam logic [7:0] S_FETCH_WAIT = 8'd3;
  localparam logic [7:0] S_DECODE     = 8'd4;
  localparam logic [7:0] S_DP_EXEC    = 8'd10;
  localparam logic [7:0] S_LD_IMM     = 8'd16;
  localparam logic [7:0] S_ST_ADDR    = 8'd17;
  localparam logic [7:0] S_LD_REG     = 8'd19;
  localparam logic [7:0] S_LD_WAIT    = 8'd20;
  localparam logic [7:0] S_LD_WB      = 8'd21;
  localparam logic [7:0] S_ST_DATA    = 8'd22;
  localparam logic [7:0] S_ST_WAIT    = 8'd23;

  localparam logic [3:0] WD_LAST = 4'(MOC_TIMEOUT - 1);

  logic [7:0] state_q, state_d;
  logic [3:0] wd_q, wd_d;
  logic       bus_err_q, bus_err_d;
  logic       in_wait, timeout;

  assign in_wait = (state_q == S_FETCH_WAIT) || (state_q == S_LD_WAIT) ||
                   (state_q == S_ST_WAIT);
  assign timeout = in_wait && !moc_i && (wd_q == WD_LAST);

  always_comb begin
    state_d      = S_RESET;
    wd_d         = 4'd0;
    bus_err_d    = bus_err_q;
    mar_ld_o     = 1'b0;
    pc_ld_o      = 1'b0;
    ir_ld_o      = 1'b0;
    mdr_ld_o     = 1'b0;
    rf_ld_o      = 1'b0;
    flags_ld_o   = 1'b0;
    mfa_o        = 1'b0;
    rw_o         = 1'b1;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;
    case (state_q)
      S_RESET:      state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: begin
        mar_ld_o = 1'b1;
        state_d  = S_FETCH_INC;
      end
      S_FETCH_INC: begin
        pc_ld_o = 1'b1;
        mfa_o   = 1'b1;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        mfa_o   = 1'b1;
        ir_ld_o = moc_i;
        state_d = moc_i ? S_DECODE : S_FETCH_WAIT;
      end
      S_DECODE: begin
        if (!cond_true_i) begin
          instr_done_o = 1'b1;
          state_d      = S_FETCH_ADDR;
        end else if (enc_state_i inside {S_DP_EXEC, S_LD_IMM, S_ST_ADDR, S_LD_REG}) begin
          state_d = enc_state_i;
        end else begin
          illegal_o    = 1'b1;
          instr_done_o = 1'b1;
          state_d      = S_FETCH_ADDR;
        end
      end
      S_DP_EXEC: begin
        rf_ld_o      = 1'b1;
        flags_ld_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH_ADDR;
      end
      S_LD_IMM, S_LD_REG: begin
        mar_ld_o = 1'b1;
        state_d  = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        mfa_o    = 1'b1;
        mdr_ld_o = moc_i;
        state_d  = moc_i ? S_LD_WB : S_LD_WAIT;
      end
      S_LD_WB: begin
        rf_ld_o      = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH_ADDR;
      end
      S_ST_ADDR: begin
        mar_ld_o = 1'b1;
        state_d  = S_ST_DATA;
      end
      S_ST_DATA: begin
        mdr_ld_o = 1'b1;
        state_d  = S_ST_WAIT;
      end
      S_ST_WAIT: begin
        mfa_o        = 1'b1;
        rw_o         = 1'b0;
        instr_done_o = moc_i;
        state_d      = moc_i ? S_FETCH_ADDR : S_ST_WAIT;
      end
      default: state_d = S_RESET;
    endcase
    // Every wait state is entered from a non-wait state, so leaving or
    // entering a wait both clear the counter; only a stall increments it.
    if (timeout) begin
      state_d   = S_RESET;
      bus_err_d = 1'b1;
    end else if (in_wait && !moc_i) begin
      wd_d = wd_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_RESET;
      wd_q      <= 4'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state_o   = state_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_arm_control_sequencer.sv
// Self-checking bench for arm_control_sequencer: instruction-level model builds
// an expected per-cycle trace that a single compare process checks.
module tb_arm_control_sequencer;

  localparam logic [10:0] MAR = 11'h400, PC = 11'h200, IR = 11'h100, MDR = 11'h080,
                          RF  = 11'h040, FL = 11'h020, MFA = 11'h010, R  = 11'h008,
                          IL  = 11'h004, DN = 11'h002, BE = 11'h001;

  typedef struct packed {
    logic [7:0]  st;
    logic        moc;
    logic        cond;
    logic [7:0]  enc;
    logic [10:0] outs;
  } step_t;

  logic       clk, reset, cond_true, moc;
  logic [7:0] enc_state, state;
  logic mar_ld, pc_ld, ir_ld, mdr_ld, rf_ld, flags_ld, mfa, rw, illegal, instr_done, bus_err;

  step_t q[$];
  step_t exp_s;
  logic  exp_valid = 1'b0;
  logic  be = 1'b0;
  int    checks = 0, failures = 0;

  arm_control_sequencer #(.MOC_TIMEOUT(15)) dut (
    .clk_i(clk), .reset_i(reset), .enc_state_i(enc_state), .cond_true_i(cond_true),
    .moc_i(moc), .state_o(state), .mar_ld_o(mar_ld), .pc_ld_o(pc_ld), .ir_ld_o(ir_ld),
    .mdr_ld_o(mdr_ld), .rf_ld_o(rf_ld), .flags_ld_o(flags_ld), .mfa_o(mfa), .rw_o(rw),
    .illegal_o(illegal), .instr_done_o(instr_done), .bus_err_o(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] dut_outs();
    return {mar_ld, pc_ld, ir_ld, mdr_ld, rf_ld, flags_ld, mfa, rw, illegal, instr_done, bus_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk($sformatf("state(exp %0d)", exp_s.st), {24'd0, state}, {24'd0, exp_s.st});
      chk($sformatf("outs(st %0d)", exp_s.st), {21'd0, dut_outs()}, {21'd0, exp_s.outs});
    end
  end

  // Non-decode cycles get random cond/enc, and non-wait cycles random moc,
  // so the DUT must prove it ignores those inputs there.
  task automatic add(input logic [7:0] st, input logic m, input logic [10:0] o);
    step_t s;
    s.st   = st;
    s.moc  = m;
    s.cond = 1'($urandom_range(0, 1));
    s.enc  = 8'($urandom_range(0, 255));
    s.outs = o | (be ? BE : 11'h000);
    q.push_back(s);
  endtask

  task automatic add_idle(input logic [7:0] st, input logic [10:0] o);
    add(st, 1'($urandom_range(0, 1)), o);
  endtask

  task automatic decode(input logic c, input logic [7:0] e, input logic [10:0] o);
    step_t s;
    s.st   = 8'd4;
    s.moc  = 1'($urandom_range(0, 1));
    s.cond = c;
    s.enc  = e;
    s.outs = o | R | (be ? BE : 11'h000);
    q.push_back(s);
  endtask

  task automatic fetch(input int w);
    add_idle(8'd1, MAR | R);
    add_idle(8'd2, PC | MFA | R);
    repeat (w) add(8'd3, 1'b0, MFA | R);
    add(8'd3, 1'b1, MFA | IR | R);
  endtask

  task automatic fetch_timeout();
    add_idle(8'd1, MAR | R);
    add_idle(8'd2, PC | MFA | R);
    repeat (15) add(8'd3, 1'b0, MFA | R);
    be = 1'b1;
    add_idle(8'd0, R);
  endtask

  task automatic dp(input int wf);
    fetch(wf);
    decode(1'b1, 8'd10, 11'h000);
    add_idle(8'd10, RF | FL | DN | R);
  endtask

  task automatic cfail(input int wf, input logic [7:0] e);
    fetch(wf);
    decode(1'b0, e, DN);
  endtask

  task automatic ill(input int wf, input logic [7:0] e);
    fetch(wf);
    decode(1'b1, e, IL | DN);
  endtask

  task automatic ld(input int wf, input logic [7:0] e, input int wl);
    fetch(wf);
    decode(1'b1, e, 11'h000);
    add_idle(e, MAR | R);
    repeat (wl) add(8'd20, 1'b0, MFA | R);
    add(8'd20, 1'b1, MFA | MDR | R);
    add_idle(8'd21, RF | DN | R);
  endtask

  task automatic st(input int wf, input int ws);
    fetch(wf);
    decode(1'b1, 8'd17, 11'h000);
    add_idle(8'd17, MAR | R);
    add_idle(8'd22, MDR | R);
    repeat (ws) add(8'd23, 1'b0, MFA);
    add(8'd23, 1'b1, MFA | DN);
  endtask

  // Entered at posedge+1; each step covers one DUT cycle, checked at negedge.
  task automatic run();
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      moc       = s.moc;
      cond_true = s.cond;
      enc_state = s.enc;
      exp_s     = s;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; moc = 1'b0; cond_true = 1'b0; enc_state = 8'd0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_state", {24'd0, state}, 32'd0);
    chk("reset_outs", {21'd0, dut_outs()}, {21'd0, R});

    add_idle(8'd0, R);
    n = q.size(); dp(0);        chk("lat_dp", q.size() - n, 5);
    n = q.size(); ld(0, 8'd16, 3); chk("lat_ld_3w", q.size() - n, 10);
    n = q.size(); st(0, 0);     chk("lat_st", q.size() - n, 7);
    n = q.size(); cfail(0, 8'd10); chk("lat_cfail", q.size() - n, 4);
    n = q.size(); ill(0, 8'd7); chk("lat_ill", q.size() - n, 4);
    n = q.size(); ld(0, 8'd19, 0); chk("lat_ld", q.size() - n, 7);
    dp(2);
    st(1, 2);
    dp(14);
    fetch_timeout();
    dp(0);
    st(0, 1);
    ill(0, 8'd255);
    cfail(1, 8'd7);

    @(posedge clk);
    #1;
    reset = 1'b0;
    run();

    fetch(0);
    decode(1'b1, 8'd16, 11'h000);
    add_idle(8'd16, MAR | R);
    add(8'd20, 1'b0, MFA | R);
    add(8'd20, 1'b0, MFA | R);
    run();
    moc = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", {24'd0, state}, 32'd0);
    chk("async_mfa", {31'd0, mfa}, 32'd0);
    chk("async_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    be = 1'b0;
    add_idle(8'd0, R);
    dp(0);
    run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
